// File: rtl/tx0_flexo_ctl_if.sv
// tx0_flexo_ctl_if: CPU, host byte link and key handshake bundle for the Flexowriter controller.
interface tx0_flexo_ctl_if;
  logic start_print;
  logic start_punch;
  logic [0:5] code_in;
  logic hole7_in;
  logic complete;
  logic tx_valid;
  logic tx_ready;
  logic [0:8] tx_data;
  logic rx_valid;
  logic [0:5] rx_data;
  logic rx_ready;
  logic [0:5] key_code;
  logic key_strobe;
  logic overrun;
  modport slave (
    input start_print, start_punch, code_in, hole7_in, tx_ready, rx_valid, rx_data,
    output complete, tx_valid, tx_data, rx_ready, key_code, key_strobe, overrun
  );
  modport master (
    output start_print, start_punch, code_in, hole7_in, tx_ready, rx_valid, rx_data,
    input complete, tx_valid, tx_data, rx_ready, key_code, key_strobe, overrun
  );
endinterface

// File: rtl/tx0_flexo_ctl.sv
// tx0_flexo_ctl: TX-0 Flexowriter controller -- paces CPU print/punch into a host FIFO and strobes keys.
// Define FLEXO_ECHO_EN to also push every strobed key into the FIFO as a print entry.
module tx0_flexo_ctl #(
  parameter int DEPTH = 4,
  parameter int CHAR_CYCLES = 1000,
  parameter int KEY_GAP = 16
) (
  input logic clk,
  input logic reset,
  tx0_flexo_ctl_if.slave f
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CHAR_CYCLES);
  localparam int GW = $clog2(KEY_GAP + 1);
  typedef enum logic [1:0] {IDLE, WAIT_SPACE, PACE, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [0:8] pend_q, pend_d;
  logic [0:8] mem_q [DEPTH];
  logic [0:8] mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [0:5] hold_code_q, hold_code_d, key_code_q, key_code_d;
  logic hold_q, hold_d;
  logic complete_q, complete_d;
  logic overrun_q, overrun_d;
  logic key_strobe_q, key_strobe_d;
  logic start, full, pop, push, fsm_push, strobe, rx_ready, rx_take;
  logic [0:8] entry, fsm_entry, push_entry;
  assign start = f.start_print | f.start_punch;
  assign entry = {f.start_print, f.start_punch, f.hole7_in, f.code_in};
  assign full = count_q == (AW + 1)'(DEPTH);
  assign pop = count_q != '0 && f.tx_ready;
  assign rx_ready = !hold_q && gap_q == '0;
  assign rx_take = f.rx_valid && rx_ready;
`ifdef FLEXO_ECHO_EN
  // A key strobe is never issued in a cycle with an FSM push, so the echo only needs FIFO space.
  assign strobe = hold_q && state_q == IDLE && !start && (!full || pop);
  assign push = fsm_push | strobe;
  assign push_entry = fsm_push ? fsm_entry : {3'b100, hold_code_q};
`else
  assign strobe = hold_q && state_q == IDLE && !start;
  assign push = fsm_push;
  assign push_entry = fsm_entry;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pend_d = pend_q;
    fsm_push = 1'b0;
    fsm_entry = pend_q;
    complete_d = 1'b0;
    overrun_d = overrun_q | (start && state_q != IDLE);
    case (state_q)
      IDLE: if (start) begin
        pend_d = entry;
        fsm_entry = entry;
        fsm_push = !full;
        state_d = full ? WAIT_SPACE : PACE;
        cnt_d = CW'(CHAR_CYCLES - 1);
      end
      WAIT_SPACE: if (!full || pop) begin
        fsm_push = 1'b1;
        state_d = PACE;
        cnt_d = CW'(CHAR_CYCLES - 1);
      end
      PACE: begin
        cnt_d = cnt_q - CW'(cnt_q != '0);
        complete_d = cnt_q == '0;
        state_d = cnt_q == '0 ? DONE : PACE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wptr_q] = push_entry;
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    hold_d = strobe ? 1'b0 : (rx_take | hold_q);
    hold_code_d = rx_take ? f.rx_data : hold_code_q;
    gap_d = strobe ? GW'(KEY_GAP) : gap_q - GW'(gap_q != '0);
    key_strobe_d = strobe;
    key_code_d = strobe ? hold_code_q : key_code_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pend_q <= '0;
      mem_q <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      gap_q <= '0;
      hold_q <= 1'b0;
      hold_code_q <= '0;
      key_code_q <= '0;
      key_strobe_q <= 1'b0;
      complete_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      mem_q <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      gap_q <= gap_d;
      hold_q <= hold_d;
      hold_code_q <= hold_code_d;
      key_code_q <= key_code_d;
      key_strobe_q <= key_strobe_d;
      complete_q <= complete_d;
      overrun_q <= overrun_d;
    end
  end
  assign f.complete = complete_q;
  assign f.tx_valid = count_q != '0;
  assign f.tx_data = mem_q[rptr_q];
  assign f.rx_ready = rx_ready;
  assign f.key_code = key_code_q;
  assign f.key_strobe = key_strobe_q;
  assign f.overrun = overrun_q;
endmodule

// File: doc/tx0_flexo_ctl.md
Name: tx0_flexo_ctl

Overview:
- Controller for the TX-0 Flexowriter port. Sequences the CPU's start_print/start_punch requests into a character FIFO and paces the flexo_complete handshake to emulate device time.
- Shares the single Flexowriter mechanism between CPU output and keyboard input: key strobes toward the CPU are held off while a character is being "printed".
- Sits between the tx0 core's flexo_* ports and a host byte link (UART bridge).

Parameters:
DEPTH, 4, output FIFO entries; power of 2, >=2
CHAR_CYCLES, 1000, clk cycles of emulated print/punch time per character; >=2
KEY_GAP, 16, minimum clk cycles between successive key strobes; >=1

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
start_print  in  1  one-cycle request from CPU: print code_in
start_punch  in  1  one-cycle request from CPU: punch code_in
code_in  in  [0:5]  character code from CPU
hole7_in  in  1  7th-hole bit from CPU
complete  out  1  one-cycle pulse to CPU: character finished
tx_valid  out  1  FIFO head valid toward host
tx_ready  in  1  host accepts head
tx_data  out  [0:8]  {print, punch, hole7, code[0:5]}
rx_valid  in  1  host offers key code
rx_data  in  [0:5]  key code from host
rx_ready  out  1  controller accepts key code
key_code  out  [0:5]  code to CPU live register
key_strobe  out  1  one-cycle pulse: load key_code into LR
overrun  out  1  sticky: start request dropped while busy

Behaviour:
- Reset (async, any time, including mid-character): FIFO emptied, FSM to IDLE, all counters 0. complete, tx_valid, key_strobe, overrun = 0; key_code = 0; rx_ready = 1.
- Output FSM states: IDLE, WAIT_SPACE, PACE, DONE.
- IDLE, start_print or start_punch high:
  - Capture entry {start_print, start_punch, hole7_in, code_in}. Both starts high in one cycle gives print=punch=1 in a single entry.
  - FIFO not full: push this cycle; go to PACE with counter = CHAR_CYCLES-1.
  - FIFO full: go to WAIT_SPACE holding the entry.
- WAIT_SPACE: push on the first cycle the FIFO is not full (a pop in the same cycle counts as space); then go to PACE.
- PACE: decrement each cycle; at 0 go to DONE.
- DONE: complete=1 for exactly one cycle; back to IDLE.
- Latency: start to complete pulse = CHAR_CYCLES+1 cycles when FIFO has space.
- A start in any state other than IDLE is dropped and sets overrun; overrun clears only on reset.
- FIFO:
  - tx_valid = not empty; tx_data = head entry; pop when tx_valid && tx_ready.
  - Simultaneous push and pop at full or empty is legal, and count is unchanged.
  - Pointers wrap modulo DEPTH.
  - Draining is independent of the FSM.
- Key path:
  - rx_ready = 1 when the key holding register is empty and the gap counter is 0.
  - rx_valid && rx_ready: latch rx_data into the holding register.
  - Strobe is issued on the first cycle with holding register full and FSM in IDLE with no start_print/start_punch that cycle (CPU output has priority).
  - At strobe: key_strobe=1 and key_code=held code for one cycle; holding register cleared; gap counter loaded KEY_GAP.
  - key_code holds its last value after the strobe.
- Gap counter: decrements to 0; rx_ready stays low while it is nonzero.

Optional Feature:
- Macro FLEXO_ECHO_EN.
- Defined: each strobed key is also pushed into the FIFO as {1,0,0,code}, emulating the typewriter printing typed keys.
  - Echo push happens in the strobe cycle.
  - If the FIFO is full, the strobe waits until space.
  - If an FSM push and an echo push fall in the same cycle, the FSM push wins and the echo waits.
  - Echo pushes do not enter PACE and produce no complete pulse.
- Not defined: keys never enter the FIFO; no echo logic is present.

Test Plan:
- CHAR_CYCLES=10, tx_ready=1: start_print with code 6'o25, hole7=1 -> tx_data=9'b101_010101 valid next cycle; complete pulses exactly 11 cycles after start; one pulse only.
- start_print and start_punch in the same cycle, code 6'o07 -> a single entry {1,1,0,000111}; one complete.
- tx_ready=0, DEPTH=4: five start/complete sequences -> FSM reaches WAIT_SPACE on the 5th with no complete; raise tx_ready for 1 cycle -> entry pushed, complete after CHAR_CYCLES+1 more cycles; FIFO order preserved.
- A second start 3 cycles into PACE -> overrun=1, no extra FIFO entry, original complete unaffected; reset -> overrun=0, tx_valid=0.
- rx_valid with code 6'o41 during PACE -> rx_ready drops after accept; key_strobe withheld until DONE->IDLE, then one pulse with key_code=6'o41; next rx_ready only after KEY_GAP cycles.
- FLEXO_ECHO_EN defined: key 6'o12 strobed -> FIFO gains {1,0,0,001010}; no complete pulse generated.
